// File: rtl/unidad_busqueda_if.sv
// rtl/unidad_busqueda_if.sv - memory and decoder bus of the instruction fetch unit
interface unidad_busqueda_if;
  logic [15:0] DatoMemoria;
  logic [15:0] DireccionMemoria;
  logic        LeerMemoria;
  logic [15:0] Instruccion;
  logic [15:0] Operando;
  logic        InstruccionValida;
  logic        InstruccionAceptada;
  logic        Salto;
  logic [15:0] DestinoSalto;
  logic        Detener;
  logic [15:0] ContadorPrograma;

  // Fetch unit side
  modport master (
    input  DatoMemoria, InstruccionAceptada, Salto, DestinoSalto, Detener,
    output DireccionMemoria, LeerMemoria, Instruccion, Operando,
           InstruccionValida, ContadorPrograma
  );

  // Memory plus decoder side
  modport slave (
    output DatoMemoria, InstruccionAceptada, Salto, DestinoSalto, Detener,
    input  DireccionMemoria, LeerMemoria, Instruccion, Operando,
           InstruccionValida, ContadorPrograma
  );
endinterface

// File: rtl/unidad_busqueda.sv
// rtl/unidad_busqueda.sv - instruction fetch unit: PC, memory read, 1/2-word assembly
module unidad_busqueda #(
  parameter logic [15:0] DIRECCION_INICIAL = 16'h0000,
  parameter logic [3:0]  CODIGO_INMEDIATO  = 4'h4
) (
  input logic               Reloj,
  input logic               Reiniciar_n,
  unidad_busqueda_if.master bus
);

  typedef enum logic [2:0] {
    INICIO,
    BUSCAR,
    CAPTURAR,
    BUSCAR_OPERANDO,
    CAPTURAR_OPERANDO,
    ENTREGAR
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] dir_q, dir_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] oper_q, oper_d;
  logic        leer_q, leer_d;
  logic        valida_q, valida_d;
  logic        salto_ok;

  // A jump is honoured everywhere except in the single post-reset cycle.
  assign salto_ok = bus.Salto && (estado_q != INICIO);

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge Reloj or negedge Reiniciar_n) begin
    if (!Reiniciar_n) begin
      estado_q <= INICIO;
      pc_q     <= DIRECCION_INICIAL;
      dir_q    <= DIRECCION_INICIAL;
      instr_q  <= 16'h0000;
      oper_q   <= 16'h0000;
      leer_q   <= 1'b0;
      valida_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      dir_q    <= dir_d;
      instr_q  <= instr_d;
      oper_q   <= oper_d;
      leer_q   <= leer_d;
      valida_q <= valida_d;
    end
  end

  // Next state. BUSCAR only moves on once a read was actually issued
  // (leer_q=1) and Detener is low, so a stall never skips the memory read.
  always_comb begin
    estado_d = estado_q;
    if (salto_ok) begin
      estado_d = BUSCAR;
    end else begin
      case (estado_q)
        INICIO:            estado_d = BUSCAR;
        BUSCAR:            if (leer_q && !bus.Detener) estado_d = CAPTURAR;
        CAPTURAR:          estado_d = (bus.DatoMemoria[15:12] == CODIGO_INMEDIATO)
                                      ? BUSCAR_OPERANDO : ENTREGAR;
        BUSCAR_OPERANDO:   estado_d = CAPTURAR_OPERANDO;
        CAPTURAR_OPERANDO: estado_d = ENTREGAR;
        ENTREGAR:          if (bus.InstruccionAceptada) estado_d = BUSCAR;
        default:           estado_d = INICIO;
      endcase
    end
  end

  // Datapath and output values for the coming cycle, derived from the next state.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    oper_d  = oper_q;
    if (salto_ok) begin
      pc_d = bus.DestinoSalto;
    end else begin
      case (estado_q)
        CAPTURAR: begin
          instr_d = bus.DatoMemoria;
          oper_d  = 16'h0000;
          pc_d    = pc_q + 16'd1;
        end
        CAPTURAR_OPERANDO: begin
          oper_d = bus.DatoMemoria;
          pc_d   = pc_q + 16'd1;
        end
        default: ;
      endcase
    end
    // The address always follows the PC, so a jump target is on the bus
    // in the very next cycle and an operand read uses the incremented PC.
    dir_d    = pc_d;
    leer_d   = ((estado_d == BUSCAR) && !bus.Detener) || (estado_d == BUSCAR_OPERANDO);
    valida_d = (estado_d == ENTREGAR);
  end

  assign bus.ContadorPrograma  = pc_q;
  assign bus.DireccionMemoria  = dir_q;
  assign bus.LeerMemoria       = leer_q;
  assign bus.Instruccion       = instr_q;
  assign bus.Operando          = oper_q;
  assign bus.InstruccionValida = valida_q;

endmodule

// File: tb/tb_unidad_busqueda.sv
// tb/tb_unidad_busqueda.sv - scoreboard bench for unidad_busqueda
module tb_unidad_busqueda;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  unidad_busqueda_if bus();
  unidad_busqueda dut (.Reloj(clk), .Reiniciar_n(rst_n), .bus(bus.master));

  // Memory: one-edge read latency, garbage on the bus when not reading
  logic [15:0] mem [0:65535];
  always @(posedge clk) bus.DatoMemoria <= bus.LeerMemoria ? mem[bus.DireccionMemoria] : 16'hBAD0;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] op;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_pc;
  logic [15:0] w;
  int          checks = 0;
  int          errors = 0;
  int          ndeliv = 0;
  int          n;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Program-level reference: next instruction starting at model_pc
  function automatic void push_expected();
    exp_t e;
    e.inst = mem[model_pc];
    e.op   = 16'h0000;
    e.pc   = model_pc + 16'd1;
    if (e.inst[15:12] == 4'h4) begin
      e.op = mem[model_pc + 16'd1];
      e.pc = model_pc + 16'd2;
    end
    sb.push_back(e);
    model_pc = e.pc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (sb.size() == 0) push_expected();
  endtask

  // Jump: an instruction handed over in this same cycle is still consumed
  task automatic do_salto(input logic [15:0] target);
    if (bus.InstruccionValida && bus.InstruccionAceptada) begin
      while (sb.size() > 1) void'(sb.pop_back());
    end else begin
      sb.delete();
    end
    model_pc = target;
    push_expected();
    bus.Salto = 1'b1;
    bus.DestinoSalto = target;
    tick();
    bus.Salto = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!bus.InstruccionValida && k < 60) begin
      tick();
      k++;
    end
    if (!bus.InstruccionValida) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: valid got 0 after 60 cycles, required 1", name);
    end
  endtask

  task automatic wait_read(input string name, input logic [15:0] addr);
    int k = 0;
    while (!(bus.LeerMemoria && bus.DireccionMemoria == addr) && k < 60) begin
      tick();
      k++;
    end
    check16({name, "_addr"}, bus.DireccionMemoria, addr);
    check1({name, "_read"}, bus.LeerMemoria, 1'b1);
  endtask

  // Monitor: every handshake is compared with the scoreboard front
  always @(negedge clk) begin
    if (rst_n && bus.InstruccionValida) begin
      check1("no_read_while_valid", bus.LeerMemoria, 1'b0);
      if (bus.InstruccionAceptada) begin
        ndeliv++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got inst %h op %h, required none", bus.Instruccion, bus.Operando);
        end else begin
          mon_e = sb.pop_front();
          check16("instruccion", bus.Instruccion, mon_e.inst);
          check16("operando", bus.Operando, mon_e.op);
          check16("pc_after", bus.ContadorPrograma, mon_e.pc);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if ($urandom_range(3) == 0) w[15:12] = 4'h4;
      mem[i] = w;
    end
    mem[0]       = 16'h4000;
    mem[1]       = 16'h0017;
    mem[2]       = 16'h1234;
    mem[3]       = 16'h4ABC;
    mem[4]       = 16'h5555;
    mem[16'h000A] = 16'h5A5A;
    mem[16'h000B] = 16'h0B0B;
    mem[16'hFFFF] = 16'h4321;
    bus.InstruccionAceptada = 1'b1;
    bus.Salto = 1'b0;
    bus.DestinoSalto = 16'h0000;
    bus.Detener = 1'b0;
    model_pc = 16'h0000;

    // Reset values, asserted asynchronously between edges
    #2 rst_n = 1'b0;
    #1;
    check1("rst_valid", bus.InstruccionValida, 1'b0);
    check1("rst_leer", bus.LeerMemoria, 1'b0);
    check16("rst_pc", bus.ContadorPrograma, 16'h0000);
    check16("rst_dir", bus.DireccionMemoria, 16'h0000);
    check16("rst_inst", bus.Instruccion, 16'h0000);
    check16("rst_op", bus.Operando, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;

    // Two-word instruction at 0, then single word at 2 held unaccepted
    wait_valid("first");
    tick();
    bus.InstruccionAceptada = 1'b0;
    wait_valid("hold");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check1("hold_valid", bus.InstruccionValida, 1'b1);
      check16("hold_inst", bus.Instruccion, 16'h1234);
      check16("hold_op", bus.Operando, 16'h0000);
      check1("hold_no_read", bus.LeerMemoria, 1'b0);
      tick();
    end
    bus.InstruccionAceptada = 1'b1;
    tick();
    wait_read("after_accept", 16'h0003);

    // Jump during operand capture of the two-word instruction at 3
    wait_read("operand_fetch", 16'h0004);
    tick();
    do_salto(16'h000A);
    check1("salto_read", bus.LeerMemoria, 1'b1);
    check16("salto_dir", bus.DireccionMemoria, 16'h000A);
    check16("salto_pc", bus.ContadorPrograma, 16'h000A);

    // Halt held over four fetch cycles
    bus.InstruccionAceptada = 1'b0;
    wait_valid("before_halt");
    bus.Detener = 1'b1;
    bus.InstruccionAceptada = 1'b1;
    tick();
    bus.InstruccionAceptada = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check1("halt_no_read", bus.LeerMemoria, 1'b0);
      check16("halt_pc", bus.ContadorPrograma, 16'h000B);
      tick();
    end
    bus.Detener = 1'b0;
    tick();
    check1("resume_read", bus.LeerMemoria, 1'b1);
    check16("resume_dir", bus.DireccionMemoria, 16'h000B);
    bus.InstruccionAceptada = 1'b1;

    // Wrap: jump to FFFF in the same cycle an instruction is consumed
    wait_valid("before_wrap");
    do_salto(16'hFFFF);
    for (int c = 0; c < 15; c++) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.InstruccionAceptada = ($urandom_range(3) != 0);
      bus.Detener = ($urandom_range(4) == 0);
      if ($urandom_range(29) == 0) do_salto(16'($urandom));
      else tick();
    end

    // Reset during a pending handshake
    bus.Detener = 1'b0;
    bus.InstruccionAceptada = 1'b0;
    wait_valid("before_reset");
    rst_n = 1'b0;
    #1;
    check1("midrst_valid", bus.InstruccionValida, 1'b0);
    check1("midrst_leer", bus.LeerMemoria, 1'b0);
    check16("midrst_pc", bus.ContadorPrograma, 16'h0000);
    sb.delete();
    model_pc = 16'h0000;
    mem[0] = 16'h1111;
    tick();
    rst_n = 1'b1;
    bus.InstruccionAceptada = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check1("restart_valid_timing", bus.InstruccionValida, (c == 4));
      tick();
    end
    for (int c = 0; c < 10; c++) tick();

    n = ndeliv;
    checks++;
    if (n < 50) begin
      errors++;
      $display("FAIL delivery_count: got %0d required at least 50", n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
